// File: rtl/mcp_rx_deserializer_if.sv
// Receive-side packet handshake between the MCP deserializer (master)
// and the MCP readout logic (slave).
interface mcp_rx_deserializer_if #(
    parameter int WIDTH = 54
);
    logic             rx_valid;
    logic             rx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_parity_err;

    modport master (
        output rx_valid,
        output rx_data,
        output rx_parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  rx_parity_err,
        output rx_ready
    );
endinterface

// File: rtl/mcp_rx_deserializer.sv
// LArPix daisy-chain return-line receiver: start/data/stop deserializer feeding a FWFT packet FIFO.
// Optional macro PARITY_CHECK_EN adds an odd-parity flag stored with each FIFO entry.
module mcp_rx_deserializer #(
    parameter int WIDTH        = 54,
    parameter int CLKS_PER_BIT = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_BITS    = 2
) (
    input  logic                 clk2x,
    input  logic                 reset,
    input  logic                 miso,
    mcp_rx_deserializer_if.master rx_if,
    output logic                 frame_err,
    output logic                 overflow,
    output logic [7:0]           overflow_cnt,
    output logic                 busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [FIFO_BITS:0] FULL_CNT = (FIFO_BITS + 1)'(FIFO_DEPTH);
`ifdef PARITY_CHECK_EN
    localparam int ENTRY_W = WIDTH + 1;
`else
    localparam int ENTRY_W = WIDTH;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    logic                 sync1_reg, sync2_reg, miso_s;
    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [BIT_W-1:0]     bitidx_reg;
    logic [WIDTH-1:0]     shift_reg;
    logic                 push_pend_reg;
    logic [ENTRY_W-1:0]   push_word_reg;
    logic                 frame_err_reg;

    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [FIFO_BITS-1:0] rd_ptr_reg, wr_ptr_reg, rd_next;
    logic [FIFO_BITS:0]   count_reg, count_next;
    logic [ENTRY_W-1:0]   head_reg;
    logic                 overflow_reg;
    logic [7:0]           ovf_cnt_reg;
    logic                 fifo_valid, fifo_full, do_pop, do_push, drop;

    // Both flops reset to the idle (high) line level so reset release never looks like a start bit.
    always_ff @(posedge clk2x or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= miso;
            sync2_reg <= sync1_reg;
        end
    end
    assign miso_s = sync2_reg;

    always_ff @(posedge clk2x or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bitidx_reg    <= '0;
            shift_reg     <= '0;
            push_pend_reg <= 1'b0;
            push_word_reg <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            push_pend_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!miso_s) begin
                        state_reg <= START;
                        cnt_reg   <= '0;
                    end
                end
                START: begin
                    if (cnt_reg == CNT_HALF) begin
                        cnt_reg    <= '0;
                        bitidx_reg <= '0;
                        state_reg  <= miso_s ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg   <= '0;
                        shift_reg <= {miso_s, shift_reg[WIDTH-1:1]};
                        if (bitidx_reg == BIT_LAST) begin
                            state_reg <= STOP;
                        end else begin
                            bitidx_reg <= bitidx_reg + BIT_W'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg <= '0;
                        if (miso_s) begin
                            push_pend_reg <= 1'b1;
`ifdef PARITY_CHECK_EN
                            push_word_reg <= {~^shift_reg, shift_reg};
`else
                            push_word_reg <= shift_reg;
`endif
                            state_reg <= IDLE;
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= BREAK;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                BREAK: begin
                    if (miso_s) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        fifo_valid = (count_reg != '0);
        fifo_full  = (count_reg == FULL_CNT);
        do_pop     = fifo_valid & rx_if.rx_ready;
        do_push    = push_pend_reg & (~fifo_full | do_pop);
        drop       = push_pend_reg & fifo_full & ~do_pop;
        rd_next    = rd_ptr_reg + FIFO_BITS'(do_pop);
        count_next = count_reg + (FIFO_BITS + 1)'(do_push) - (FIFO_BITS + 1)'(do_pop);
    end

    always_ff @(posedge clk2x) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_word_reg;
        end
    end

    // The head register mirrors the next head entry; it bypasses the array when the
    // entry being written this cycle becomes the head, and holds when the FIFO drains.
    always_ff @(posedge clk2x or posedge reset) begin
        if (reset) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            head_reg     <= '0;
            overflow_reg <= 1'b0;
            ovf_cnt_reg  <= '0;
        end else begin
            overflow_reg <= drop;
            if (drop && ovf_cnt_reg != 8'hFF) begin
                ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
            end
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + FIFO_BITS'(1);
            end
            rd_ptr_reg <= rd_next;
            count_reg  <= count_next;
            if (count_next != '0) begin
                head_reg <= (do_push && wr_ptr_reg == rd_next) ? push_word_reg : mem[rd_next];
            end
        end
    end

    assign rx_if.rx_valid = fifo_valid;
    assign rx_if.rx_data  = head_reg[WIDTH-1:0];
`ifdef PARITY_CHECK_EN
    assign rx_if.rx_parity_err = head_reg[WIDTH];
`else
    assign rx_if.rx_parity_err = 1'b0;
`endif
    assign frame_err    = frame_err_reg;
    assign overflow     = overflow_reg;
    assign overflow_cnt = ovf_cnt_reg;
    assign busy         = (state_reg != IDLE);
endmodule

// File: tb/tb_mcp_rx_deserializer.sv
// Directed self-checking bench for mcp_rx_deserializer: framing, parity, FIFO overflow, glitch and reset cases.
module tb_mcp_rx_deserializer;
    localparam int W   = 54;
    localparam int CPB = 2;
`ifdef PARITY_CHECK_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    logic       clk2x = 1'b0;
    logic       reset = 1'b1;
    logic       miso  = 1'b1;
    logic       frame_err, overflow, busy;
    logic [7:0] overflow_cnt;

    mcp_rx_deserializer_if #(.WIDTH(W)) rx_if ();

    mcp_rx_deserializer #(
        .WIDTH(W), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .FIFO_BITS(2)
    ) dut (
        .clk2x(clk2x),
        .reset(reset),
        .miso(miso),
        .rx_if(rx_if.master),
        .frame_err(frame_err),
        .overflow(overflow),
        .overflow_cnt(overflow_cnt),
        .busy(busy)
    );

    always #5 clk2x = ~clk2x;

    int total = 0;
    int bad   = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    logic [W:0] popped [$];

    // One line per accepted packet; pulses and pops are counted here and read as deltas by the tests.
    always @(negedge clk2x) begin
        if (!reset) begin
            if (frame_err) fe_seen++;
            if (overflow) ov_seen++;
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                popped.push_back({rx_if.rx_parity_err, rx_if.rx_data});
                $display("rx packet data=%h parity_err=%0b", rx_if.rx_data, rx_if.rx_parity_err);
            end
        end
    end

    task automatic send_bit(input logic b);
        miso = b;
        repeat (CPB) @(posedge clk2x);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < W; i++) send_bit(d[i]);
        send_bit(stop_b);
    endtask

    task automatic idle(input int n);
        miso = 1'b1;
        repeat (n) @(posedge clk2x);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        miso  = 1'b1;
        rx_if.rx_ready = 1'b0;
        repeat (3) @(posedge clk2x);
        #1;
        total++; if (rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rx_if.rx_valid); end
        total++; if (rx_if.rx_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", rx_if.rx_data); end
        total++; if (rx_if.rx_parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity got=%b want=0", rx_if.rx_parity_err); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        total++; if (overflow_cnt !== 8'd0) begin bad++; $display("FAIL reset_ovf_cnt got=%0d want=0", overflow_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        reset = 1'b0;
        idle(4);
    endtask

    task automatic test_single_frame;
        int p0, f0;
        rx_if.rx_ready = 1'b1;
        p0 = popped.size();
        f0 = fe_seen;
        send_frame(54'h2_0_0000_0000_0003, 1'b1);
        idle(6);
        total++; if (popped.size() - p0 !== 1) begin bad++; $display("FAIL single_beats got=%0d want=1", popped.size() - p0); end
        if (popped.size() > p0) begin
            total++; if (popped[p0][W-1:0] !== 54'h2_0_0000_0000_0003) begin bad++; $display("FAIL single_data got=%h want=%h", popped[p0][W-1:0], 54'h2_0_0000_0000_0003); end
            total++; if (popped[p0][W] !== 1'b0) begin bad++; $display("FAIL single_parity got=%b want=0", popped[p0][W]); end
        end
        total++; if (fe_seen - f0 !== 0) begin bad++; $display("FAIL single_frame_err got=%0d want=0", fe_seen - f0); end
    endtask

    task automatic test_parity;
        int p0;
        rx_if.rx_ready = 1'b1;
        p0 = popped.size();
        send_frame(54'h2_0_0000_0000_0001, 1'b1);
        idle(6);
        total++; if (popped.size() - p0 !== 1) begin bad++; $display("FAIL parity_beats got=%0d want=1", popped.size() - p0); end
        if (popped.size() > p0) begin
            total++; if (popped[p0][W-1:0] !== 54'h2_0_0000_0000_0001) begin bad++; $display("FAIL parity_data got=%h want=%h", popped[p0][W-1:0], 54'h2_0_0000_0000_0001); end
            total++; if (popped[p0][W] !== PAR_ON) begin bad++; $display("FAIL parity_flag got=%b want=%b", popped[p0][W], PAR_ON); end
        end
    endtask

    task automatic test_frame_error;
        int p0, f0;
        rx_if.rx_ready = 1'b1;
        p0 = popped.size();
        f0 = fe_seen;
        send_frame(54'h155, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy got=%b want=1", busy); end
        idle(6);
        total++; if (fe_seen - f0 !== 1) begin bad++; $display("FAIL frame_err_pulses got=%0d want=1", fe_seen - f0); end
        total++; if (popped.size() - p0 !== 0) begin bad++; $display("FAIL frame_err_beats got=%0d want=0", popped.size() - p0); end
        total++; if (rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL frame_err_valid got=%b want=0", rx_if.rx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL frame_err_idle got=%b want=0", busy); end
        send_frame(54'h1, 1'b1);
        idle(6);
        total++; if (popped.size() - p0 !== 1) begin bad++; $display("FAIL after_break_beats got=%0d want=1", popped.size() - p0); end
        if (popped.size() > p0) begin
            total++; if (popped[p0][W-1:0] !== 54'h1) begin bad++; $display("FAIL after_break_data got=%h want=1", popped[p0][W-1:0]); end
        end
    endtask

    task automatic test_back_to_back_overflow;
        int p0, o0, n;
        logic [3:0] par_tab;
        par_tab = 4'b0100;  // payload 3 has even popcount
        rx_if.rx_ready = 1'b0;
        p0 = popped.size();
        o0 = ov_seen;
        for (int k = 1; k <= 6; k++) send_frame(W'(k), 1'b1);
        idle(6);
        total++; if (ov_seen - o0 !== 2) begin bad++; $display("FAIL ovf_pulses got=%0d want=2", ov_seen - o0); end
        total++; if (overflow_cnt !== 8'd2) begin bad++; $display("FAIL ovf_cnt got=%0d want=2", overflow_cnt); end
        total++; if (rx_if.rx_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b want=1", rx_if.rx_valid); end
        total++; if (rx_if.rx_data !== 54'h1) begin bad++; $display("FAIL ovf_head got=%h want=1", rx_if.rx_data); end
        total++; if (popped.size() - p0 !== 0) begin bad++; $display("FAIL ovf_no_pop got=%0d want=0", popped.size() - p0); end
        rx_if.rx_ready = 1'b1;
        idle(8);
        n = popped.size() - p0;
        total++; if (n !== 4) begin bad++; $display("FAIL drain_beats got=%0d want=4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            total++; if (popped[p0+i][W-1:0] !== W'(i + 1)) begin bad++; $display("FAIL drain_data%0d got=%h want=%h", i, popped[p0+i][W-1:0], W'(i + 1)); end
            total++; if (popped[p0+i][W] !== (PAR_ON & par_tab[i])) begin bad++; $display("FAIL drain_parity%0d got=%b want=%b", i, popped[p0+i][W], PAR_ON & par_tab[i]); end
        end
        total++; if (rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", rx_if.rx_valid); end
    endtask

    task automatic test_glitch;
        int p0, f0;
        logic saw_busy;
        rx_if.rx_ready = 1'b1;
        p0 = popped.size();
        f0 = fe_seen;
        saw_busy = 1'b0;
        miso = 1'b0;
        @(posedge clk2x);
        #1;
        miso = 1'b1;
        repeat (6) begin
            @(posedge clk2x);
            #1;
            if (busy) saw_busy = 1'b1;
        end
        total++; if (saw_busy !== 1'b1) begin bad++; $display("FAIL glitch_start_seen got=%b want=1", saw_busy); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b want=0", busy); end
        idle(4);
        total++; if (popped.size() - p0 !== 0) begin bad++; $display("FAIL glitch_beats got=%0d want=0", popped.size() - p0); end
        total++; if (fe_seen - f0 !== 0) begin bad++; $display("FAIL glitch_frame_err got=%0d want=0", fe_seen - f0); end
    endtask

    task automatic test_reset_mid_frame;
        int p0;
        logic [W-1:0] d;
        d = 54'h9;
        rx_if.rx_ready = 1'b0;
        send_frame(54'h7, 1'b1);
        send_frame(54'h8, 1'b1);
        idle(6);
        total++; if (rx_if.rx_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want=1", rx_if.rx_valid); end
        total++; if (rx_if.rx_data !== 54'h7) begin bad++; $display("FAIL mid_pre_head got=%h want=7", rx_if.rx_data); end
        send_bit(1'b0);
        for (int i = 0; i <= 20; i++) send_bit(d[i]);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
        miso  = 1'b1;
        reset = 1'b1;
        #1;
        total++; if (rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b want=0", rx_if.rx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
        total++; if (overflow_cnt !== 8'd0) begin bad++; $display("FAIL mid_reset_ovf_cnt got=%0d want=0", overflow_cnt); end
        total++; if (rx_if.rx_data !== '0) begin bad++; $display("FAIL mid_reset_data got=%h want=0", rx_if.rx_data); end
        repeat (2) @(posedge clk2x);
        #1;
        reset = 1'b0;
        idle(4);
        rx_if.rx_ready = 1'b1;
        p0 = popped.size();
        send_frame(54'h2A5A5, 1'b1);
        idle(6);
        total++; if (popped.size() - p0 !== 1) begin bad++; $display("FAIL post_reset_beats got=%0d want=1", popped.size() - p0); end
        if (popped.size() > p0) begin
            total++; if (popped[p0][W-1:0] !== 54'h2A5A5) begin bad++; $display("FAIL post_reset_data got=%h want=2a5a5", popped[p0][W-1:0]); end
        end
    endtask

    initial begin
        rx_if.rx_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_parity();
        test_frame_error();
        test_back_to_back_overflow();
        test_glitch();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
